// File: rtl/alu4_share_arb.sv
// alu4_share_arb: shares one combinational alu4 between two requesters.
// Round-robin grant, operands sequenced SETUP -> EXEC so that alu_sel is
// parked at 0 between ops, result captured and returned tagged with the id.
// Optional grant statistics: define ALU_ARB_STATS_EN to add gnt_cnt0/gnt_cnt1.
module alu4_share_arb #(
  parameter int DATA_W     = 4,
  parameter int SEL_W      = 3,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_v,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_out,
  output logic              rsp_c,
  output logic              rsp_z,
  output logic              rsp_v
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]        gnt_cnt0,
  output logic [7:0]        gnt_cnt1
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                id_q, id_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_out_q, rsp_out_d;
  logic                rsp_c_q, rsp_c_d;
  logic                rsp_z_q, rsp_z_d;
  logic                rsp_v_q, rsp_v_d;
  logic                grant0, grant1;

  assign grant0 = req0_valid & (~req1_valid | ~rr_q);
  assign grant1 = req1_valid & (~req0_valid | rr_q);

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_v     = rsp_v_q;

  // Next-state, operand latch, result capture and handshake outputs.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    a_d        = a_q;
    b_d        = b_q;
    sel_d      = sel_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    rsp_id_d   = rsp_id_q;
    rsp_out_d  = rsp_out_q;
    rsp_c_d    = rsp_c_q;
    rsp_z_d    = rsp_z_q;
    rsp_v_d    = rsp_v_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_sel    = '0;
    case (state_q)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) begin
          a_d     = grant1 ? req1_a   : req0_a;
          b_d     = grant1 ? req1_b   : req0_b;
          sel_d   = grant1 ? req1_sel : req0_sel;
          id_d    = grant1;
          rr_d    = ~grant1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_sel = sel_q;
        if (cnt_q == SETTLE_LAST) begin
          rsp_id_d  = id_q;
          rsp_out_d = alu_out;
          rsp_c_d   = alu_c;
          rsp_z_d   = alu_z;
          rsp_v_d   = alu_v;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rr_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sel_q     <= '0;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      rsp_id_q  <= 1'b0;
      rsp_out_q <= '0;
      rsp_c_q   <= 1'b0;
      rsp_z_q   <= 1'b0;
      rsp_v_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sel_q     <= sel_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      rsp_id_q  <= rsp_id_d;
      rsp_out_q <= rsp_out_d;
      rsp_c_q   <= rsp_c_d;
      rsp_z_q   <= rsp_z_d;
      rsp_v_q   <= rsp_v_d;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [7:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [7:0] gnt_cnt1_q, gnt_cnt1_d;

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;

  // Saturating per-requester handshake counters.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (req0_valid && req0_ready && gnt_cnt0_q != 8'hFF) gnt_cnt0_d = gnt_cnt0_q + 8'd1;
    if (req1_valid && req1_ready && gnt_cnt1_q != 8'hFF) gnt_cnt1_d = gnt_cnt1_q + 8'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end
`endif

endmodule
